wb_arb_stage: RTL and testbench
===============================

# wb_arb_stage

Multi-channel, buffered writeback stage replacing the single-source combinational writeback. Accepts results from NUM_CH producer channels (e.g. ALU pipe, load pipe, multi-cycle mul/div). Each result is formatted at entry: ALU, memory and PC-next selection plus load sign/zero extension. Entries queue in per-channel FIFOs. A round-robin arbiter drains one entry per cycle onto the single registered register-file write port. Exports a pending-destination mask for the hazard unit.

## Interface
- XLEN, 32: datapath width.
- NUM_CH, 3: number of producer channels, ≥1.
- DEPTH, 4: entries per channel FIFO, power of two, ≥2.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_vld  in  NUM_CH  per-channel result valid.
- in_rdy  out  NUM_CH  per-channel ready; transfer when vld & rdy at a rising edge.
- in_wb_sel  in  NUM_CH×2  select: 00 ALU, 01 DOUT, 10 PC_NEXT, 11 NONE.
- in_ld_fmt  in  NUM_CH×3  load funct3, used only when sel=DOUT.
- in_alu_res, in_mem_dout, in_pc_next  in  NUM_CH×XLEN each  candidate sources; mem_dout is right-aligned.
- in_rd  in  NUM_CH×5  destination register.
- WB_data  out  XLEN  write data, registered.
- WB_rd  out  5  write address, registered.
- WB_we  out  1  write enable, registered.
- pend_mask  out  32  bit r=1 while any FIFO entry or the output register targets r; bit 0 is always 0.

## Operation
- Formatting at accept:
  - ALU → alu_res.
  - DOUT → extended mem_dout: 000 LB sign-extend [7:0]; 001 LH sign-extend [15:0]; 100 LBU and 101 LHU zero-extend; 010 and all other codes pass full word.
  - PC_NEXT → pc_next.
- Drop rule: transfers with sel=NONE or rd=0 are accepted (rdy honoured) but not enqueued. They never produce WB_we.
- in_rdy[c] = FIFO c not full and rst deasserted. There is no same-cycle pass-through when full, even if FIFO c is dequeued that cycle.
- FIFO entry holds {data, rd}. Order within a channel is preserved.
- Arbiter: searches non-empty FIFOs starting at rr_ptr and grants the first found.
  - On grant: pop the head, load the output register with WB_we=1, set rr_ptr = (grant+1) mod NUM_CH.
  - No grant: WB_we=0, WB_data and WB_rd hold, rr_ptr unchanged.
- No cross-channel ordering: two channels targeting the same rd may retire in either order. The upstream issue logic must stall on pend_mask[rd] to prevent WAW.
- pend_mask is combinational: OR of one-hot(rd) over valid FIFO entries and over the output register when WB_we=1.

## Timing
- Accept at edge N → entry visible in FIFO during cycle N+1. Uncontended grant in N+1 → WB_we/WB_rd/WB_data valid during cycle N+2. Minimum latency is 2; the register file writes at the end of N+2.
- Throughput: one writeback per cycle aggregate. Each channel gets ≥1 grant per NUM_CH cycles while non-empty.
- Simultaneous push and pop on the same FIFO is legal when not full; occupancy is unchanged.
- Reset (rst low, async):
  - All FIFOs empty, pointers 0, rr_ptr=0.
  - WB_data=0, WB_rd=0, WB_we=0, pend_mask=0, in_rdy=0.
  - Queued entries are discarded; no write occurs after release.
  - in_rdy rises the first cycle after release.

## Structure
- Package wb_pkg holds:
  - WB_SEL_ALU/DOUT/PC_NEXT/NONE, ZERO_REG.
  - LD_LB/LH/LW/LBU/LHU funct3 constants.
  - Typedef wb_entry_t {logic [XLEN-1:0] data; logic [4:0] rd;}.
- Sub-module wb_fifo: parametrised DEPTH, async active-low reset, push/pop/full/empty, exposes entry array and valid bits for the mask. Instantiated NUM_CH times.
- The top level holds the formatting function, the round-robin arbiter and the output register.

## Test plan
- Single ALU result: ch0 sel=00, alu_res=0x1234_5678, rd=5, accepted cycle 0 → WB_we=1, rd=5, data=0x1234_5678 in cycle 2; pend_mask[5]=1 in cycles 1–2 and 0 in cycle 3.
- Load formatting on ch1, sel=01:
  - dout=0x0000_0080 LB → 0xFFFF_FF80.
  - Same dout, LBU → 0x0000_0080.
  - dout=0x0000_8001 LH → 0xFFFF_8001.
  - Same dout, LHU → 0x0000_8001.
  - dout=0xDEAD_BEEF LW → 0xDEAD_BEEF.
- PC_NEXT: sel=10, pc_next=0x0000_0104, rd=1 → WB_data=0x0000_0104, WB_rd=1.
- Contention, NUM_CH=3: all channels valid in cycle 0 with rd=1,2,3 → writes rd1, rd2, rd3 in cycles 2, 3, 4. A second burst in cycle 5 starts again at ch0.
- Back-pressure, DEPTH=4: ch0, ch1, ch2 push every cycle → in_rdy[c] drops once FIFO c is full. The per-channel written rd sequence equals the pushed sequence, with no loss or duplicate. Aggregate WB_we=1 every cycle.
- Drops and reset: rd=0 or sel=11 transfers are accepted with in_rdy=1 and never raise WB_we. Pull rst low with 3 entries queued → all outputs and pend_mask 0 immediately; no WB_we after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback-stage constants: source selects, load funct3 codes and the queue entry type.
package wb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU     = 2'b00;
  localparam logic [1:0] WB_SEL_DOUT    = 2'b01;
  localparam logic [1:0] WB_SEL_PC_NEXT = 2'b10;
  localparam logic [1:0] WB_SEL_NONE    = 2'b11;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-channel writeback queue; exposes every slot and its valid bit so the top can build the pending mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  entry_t               push_entry,
  input  logic                 pop,
  output entry_t               pop_entry,
  output logic                 full,
  output logic                 empty,
  output entry_t [DEPTH-1:0]   entries,
  output logic   [DEPTH-1:0]   valid
);

  localparam int AW = $clog2(DEPTH);

  entry_t [DEPTH-1:0] mem;
  logic   [DEPTH-1:0] vld;
  logic   [DEPTH-1:0] vld_nxt;
  logic   [AW-1:0]    wr_idx;
  logic   [AW-1:0]    rd_idx;
  logic               do_push;
  logic               do_pop;

  // Guard here as well so a misbehaving caller cannot corrupt occupancy.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    vld_nxt = vld;
    if (do_pop)  vld_nxt[rd_idx] = 1'b0;
    if (do_push) vld_nxt[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      vld    <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      vld <= vld_nxt;
      if (do_push) begin
        mem[wr_idx] <= push_entry;
        wr_idx      <= wr_idx + 1'b1;
      end
      if (do_pop) rd_idx <= rd_idx + 1'b1;
    end
  end

  assign full      = &vld;
  assign empty     = ~|vld;
  assign pop_entry = mem[rd_idx];
  assign entries   = mem;
  assign valid     = vld;

endmodule

// File: rtl/wb_arb_stage.sv
// Buffered multi-channel writeback: formats results at accept, queues them per channel and
// drains one entry per cycle round-robin onto a registered register-file write port.
module wb_arb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      in_vld,
  output logic [NUM_CH-1:0]      in_rdy,
  input  logic [NUM_CH*2-1:0]    in_wb_sel,
  input  logic [NUM_CH*3-1:0]    in_ld_fmt,
  input  logic [NUM_CH*XLEN-1:0] in_alu_res,
  input  logic [NUM_CH*XLEN-1:0] in_mem_dout,
  input  logic [NUM_CH*XLEN-1:0] in_pc_next,
  input  logic [NUM_CH*5-1:0]    in_rd,
  output logic [XLEN-1:0]        WB_data,
  output logic [4:0]             WB_rd,
  output logic                   WB_we,
  output logic [31:0]            pend_mask
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Same layout as wb_entry_t, but its width follows XLEN.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
  } entry_t;

  function automatic logic [XLEN-1:0] fmt_data(
    input logic [1:0]      sel,
    input logic [2:0]      f3,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] dout,
    input logic [XLEN-1:0] pc
  );
    logic [XLEN-1:0] res;
    res = '0;
    case (sel)
      WB_SEL_ALU:     res = alu;
      WB_SEL_PC_NEXT: res = pc;
      WB_SEL_DOUT: begin
        case (f3)
          LD_LB:   res = {{(XLEN-8){dout[7]}}, dout[7:0]};
          LD_LH:   res = {{(XLEN-16){dout[15]}}, dout[15:0]};
          LD_LBU:  res = {{(XLEN-8){1'b0}}, dout[7:0]};
          LD_LHU:  res = {{(XLEN-16){1'b0}}, dout[15:0]};
          LD_LW:   res = dout;
          default: res = dout;
        endcase
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  logic                rdy_en;
  logic [NUM_CH-1:0]   push;
  logic [NUM_CH-1:0]   pop;
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   empty;
  entry_t              push_entries [NUM_CH];
  entry_t              pop_entries  [NUM_CH];
  entry_t [DEPTH-1:0]  ch_entries   [NUM_CH];
  logic   [DEPTH-1:0]  ch_valid     [NUM_CH];
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       grant_idx;
  logic                grant_vld;

  // in_rdy is held low through reset and for the release cycle, then rises on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  // Handshake: a channel transfers on a rising edge where in_vld & in_rdy; in_rdy
  // depends only on FIFO fullness, never on in_vld or on a same-cycle dequeue.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic keep;

    assign in_rdy[c] = rdy_en && !full[c];
    // NONE selects and x0 destinations complete the handshake but never reach a queue.
    assign keep = (in_wb_sel[c*2 +: 2] != WB_SEL_NONE) && (in_rd[c*5 +: 5] != ZERO_REG);
    assign push[c] = in_vld[c] && in_rdy[c] && keep;
    assign pop[c]  = grant_vld && (grant_idx == CW'(c));

    assign push_entries[c].data = fmt_data(in_wb_sel[c*2 +: 2], in_ld_fmt[c*3 +: 3],
                                           in_alu_res[c*XLEN +: XLEN],
                                           in_mem_dout[c*XLEN +: XLEN],
                                           in_pc_next[c*XLEN +: XLEN]);
    assign push_entries[c].rd   = in_rd[c*5 +: 5];

    wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[c]),
      .push_entry (push_entries[c]),
      .pop        (pop[c]),
      .pop_entry  (pop_entries[c]),
      .full       (full[c]),
      .empty      (empty[c]),
      .entries    (ch_entries[c]),
      .valid      (ch_valid[c])
    );
  end

  // First non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && !empty[(int'(rr_ptr) + i) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_idx = CW'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      WB_data <= '0;
      WB_rd   <= '0;
      WB_we   <= 1'b0;
    end else begin
      WB_we <= grant_vld;
      if (grant_vld) begin
        WB_data <= pop_entries[grant_idx].data;
        WB_rd   <= pop_entries[grant_idx].rd;
        rr_ptr  <= (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int d = 0; d < DEPTH; d++) begin
        if (ch_valid[c][d]) pend_mask[ch_entries[c][d].rd] = 1'b1;
      end
    end
    if (WB_we) pend_mask[WB_rd] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arb_stage.sv
// Directed bench for wb_arb_stage: formatting, latency, round-robin order, back-pressure, drops and reset.
module tb_wb_arb_stage;
  import wb_pkg::*;

  localparam int XLEN   = 32;
  localparam int NUM_CH = 3;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH-1:0]      in_vld;
  logic [NUM_CH-1:0]      in_rdy;
  logic [NUM_CH*2-1:0]    in_wb_sel;
  logic [NUM_CH*3-1:0]    in_ld_fmt;
  logic [NUM_CH*XLEN-1:0] in_alu_res;
  logic [NUM_CH*XLEN-1:0] in_mem_dout;
  logic [NUM_CH*XLEN-1:0] in_pc_next;
  logic [NUM_CH*5-1:0]    in_rd;
  logic [XLEN-1:0]        WB_data;
  logic [4:0]             WB_rd;
  logic                   WB_we;
  logic [31:0]            pend_mask;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  logic [4:0] exp_q2[$];

  wb_arb_stage #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_wb_sel   (in_wb_sel),
    .in_ld_fmt   (in_ld_fmt),
    .in_alu_res  (in_alu_res),
    .in_mem_dout (in_mem_dout),
    .in_pc_next  (in_pc_next),
    .in_rd       (in_rd),
    .WB_data     (WB_data),
    .WB_rd       (WB_rd),
    .WB_we       (WB_we),
    .pend_mask   (pend_mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_vld      = '0;
    in_wb_sel   = '0;
    in_ld_fmt   = '0;
    in_alu_res  = '0;
    in_mem_dout = '0;
    in_pc_next  = '0;
    in_rd       = '0;
  endtask

  task automatic set_ch(input int c, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] dout,
                        input logic [31:0] pc, input logic [4:0] rd);
    in_vld[c]               = 1'b1;
    in_wb_sel[c*2 +: 2]     = sel;
    in_ld_fmt[c*3 +: 3]     = f3;
    in_alu_res[c*32 +: 32]  = alu;
    in_mem_dout[c*32 +: 32] = dout;
    in_pc_next[c*32 +: 32]  = pc;
    in_rd[c*5 +: 5]         = rd;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated transfer: accept, check pending, check write two edges later, check idle.
  task automatic run_one(input string tag, input int c, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] dout, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [31:0] exp_data);
    set_ch(c, sel, f3, alu, dout, pc, rd);
    check({tag, "_rdy"}, 32'(in_rdy[c]), 32'd1);
    step();
    clear_in();
    check({tag, "_pend1"}, 32'(pend_mask[rd]), 32'd1);
    check({tag, "_we1"}, 32'(WB_we), 32'd0);
    step();
    check({tag, "_we2"}, 32'(WB_we), 32'd1);
    check({tag, "_rd"}, 32'(WB_rd), 32'(rd));
    check({tag, "_data"}, WB_data, exp_data);
    step();
    check({tag, "_we3"}, 32'(WB_we), 32'd0);
    check({tag, "_pend3"}, pend_mask, 32'd0);
  endtask

  // scoreboard state for the back-pressure phase
  int          npush [3];
  int          nwr;
  int          first_cyc;
  int          last_cyc;
  logic [2:0]  saw_block;
  logic [4:0]  r;
  logic [4:0]  exp_rd;
  int          qsize;
  int          ch;

  initial begin
    rst = 1'b0;
    clear_in();
    #12;
    check("rst_we", 32'(WB_we), 32'd0);
    check("rst_data", WB_data, 32'd0);
    check("rst_rd", 32'(WB_rd), 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_rdy", 32'(in_rdy), 32'd0);
    step();
    rst = 1'b1;
    check("rel_rdy0", 32'(in_rdy), 32'd0);
    step();
    check("rel_rdy1", 32'(in_rdy), 32'h7);

    // single ALU result
    run_one("alu", 0, WB_SEL_ALU, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 32'h1234_5678);

    // load formatting on ch1
    run_one("lb",  1, WB_SEL_DOUT, LD_LB,  32'h0, 32'h0000_0080, 32'h0, 5'd7, 32'hFFFF_FF80);
    run_one("lbu", 1, WB_SEL_DOUT, LD_LBU, 32'h0, 32'h0000_0080, 32'h0, 5'd7, 32'h0000_0080);
    run_one("lh",  1, WB_SEL_DOUT, LD_LH,  32'h0, 32'h0000_8001, 32'h0, 5'd8, 32'hFFFF_8001);
    run_one("lhu", 1, WB_SEL_DOUT, LD_LHU, 32'h0, 32'h0000_8001, 32'h0, 5'd8, 32'h0000_8001);
    run_one("lw",  1, WB_SEL_DOUT, LD_LW,  32'h0, 32'hDEAD_BEEF, 32'h0, 5'd9, 32'hDEAD_BEEF);
    run_one("f3_011", 1, WB_SEL_DOUT, 3'b011, 32'h0, 32'h8765_4381, 32'h0, 5'd9, 32'h8765_4381);

    // PC_NEXT on ch2
    run_one("pc", 2, WB_SEL_PC_NEXT, 3'b000, 32'h0, 32'h0, 32'h0000_0104, 5'd1, 32'h0000_0104);

    // contention: rr_ptr is back at 0 after the ch2 grant
    set_ch(0, WB_SEL_ALU, 3'b000, 32'h100, 32'h0, 32'h0, 5'd1);
    set_ch(1, WB_SEL_ALU, 3'b000, 32'h101, 32'h0, 32'h0, 5'd2);
    set_ch(2, WB_SEL_ALU, 3'b000, 32'h102, 32'h0, 32'h0, 5'd3);
    step();
    clear_in();
    check("cont_pend", pend_mask, 32'h0000_000E);
    step();
    check("cont_c2_rd", 32'(WB_rd), 32'd1);
    check("cont_c2_data", WB_data, 32'h100);
    step();
    check("cont_c3_rd", 32'(WB_rd), 32'd2);
    check("cont_c3_data", WB_data, 32'h101);
    step();
    check("cont_c4_rd", 32'(WB_rd), 32'd3);
    check("cont_c4_we", 32'(WB_we), 32'd1);
    check("cont_c4_data", WB_data, 32'h102);
    // second burst, again from ch0
    set_ch(0, WB_SEL_ALU, 3'b000, 32'h200, 32'h0, 32'h0, 5'd4);
    set_ch(1, WB_SEL_ALU, 3'b000, 32'h201, 32'h0, 32'h0, 5'd5);
    set_ch(2, WB_SEL_ALU, 3'b000, 32'h202, 32'h0, 32'h0, 5'd6);
    step();
    clear_in();
    check("burst2_idle_we", 32'(WB_we), 32'd0);
    step();
    check("burst2_rd0", 32'(WB_rd), 32'd4);
    step();
    check("burst2_rd1", 32'(WB_rd), 32'd5);
    step();
    check("burst2_rd2", 32'(WB_rd), 32'd6);
    step();
    check("burst2_done_we", 32'(WB_we), 32'd0);

    // back-pressure: every channel pushes every cycle until 8 entries each
    npush     = '{0, 0, 0};
    nwr       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    saw_block = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        if (npush[c] < 8) begin
          r = 5'(c * 10 + npush[c] + 1);
          set_ch(c, WB_SEL_ALU, 3'b000, 32'hA000_0000 | 32'(r), 32'h0, 32'h0, r);
          if (in_rdy[c]) begin
            case (c)
              0: exp_q0.push_back(r);
              1: exp_q1.push_back(r);
              default: exp_q2.push_back(r);
            endcase
            npush[c]++;
          end else begin
            saw_block[c] = 1'b1;
          end
        end else begin
          in_vld[c] = 1'b0;
        end
      end
      step();
      if (WB_we) begin
        nwr++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        ch = int'(WB_rd) / 10;
        case (ch)
          0: qsize = exp_q0.size();
          1: qsize = exp_q1.size();
          default: qsize = exp_q2.size();
        endcase
        check("bp_q_nonempty", 32'(qsize > 0), 32'd1);
        if (qsize > 0) begin
          case (ch)
            0: exp_rd = exp_q0.pop_front();
            1: exp_rd = exp_q1.pop_front();
            default: exp_rd = exp_q2.pop_front();
          endcase
          check("bp_rd", 32'(WB_rd), 32'(exp_rd));
          check("bp_data", WB_data, 32'hA000_0000 | 32'(exp_rd));
        end
      end
    end
    clear_in();
    check("bp_writes", 32'(nwr), 32'd24);
    check("bp_span", 32'(last_cyc - first_cyc + 1), 32'd24);
    check("bp_blocked", 32'(saw_block), 32'h7);
    check("bp_q_left", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);
    check("bp_pend_end", pend_mask, 32'd0);

    // drops: sel=NONE and rd=0 are accepted but never written
    set_ch(0, WB_SEL_NONE, 3'b000, 32'h55, 32'h0, 32'h0, 5'd9);
    set_ch(1, WB_SEL_ALU,  3'b000, 32'h66, 32'h0, 32'h0, 5'd0);
    check("drop_rdy", 32'(in_rdy), 32'h7);
    step();
    clear_in();
    check("drop_pend", pend_mask, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_we", 32'(WB_we), 32'd0);
    end

    // reset with three entries queued
    set_ch(0, WB_SEL_ALU, 3'b000, 32'h300, 32'h0, 32'h0, 5'd3);
    set_ch(1, WB_SEL_ALU, 3'b000, 32'h301, 32'h0, 32'h0, 5'd4);
    set_ch(2, WB_SEL_ALU, 3'b000, 32'h302, 32'h0, 32'h0, 5'd5);
    step();
    clear_in();
    check("q3_pend", pend_mask, 32'h0000_0038);
    rst = 1'b0;
    #1;
    check("arst_we", 32'(WB_we), 32'd0);
    check("arst_data", WB_data, 32'd0);
    check("arst_rd", 32'(WB_rd), 32'd0);
    check("arst_pend", pend_mask, 32'd0);
    check("arst_rdy", 32'(in_rdy), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_we", 32'(WB_we), 32'd0);
      check("post_rst_pend", pend_mask, 32'd0);
    end
    check("post_rst_rdy", 32'(in_rdy), 32'h7);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
